uart_rx_buffered: RTL and testbench
===================================

// Module: uart_rx_buffered
// PURPOSE
//  Next-generation UART receiver for tinyQV peripherals: runtime bit-rate divider, optional parity,
//  1/2 stop bits, start-bit glitch reject, break detect and an N-deep receive FIFO with RTS flow control.
//  Sits between the uart_rxd pin and the peripheral register interface; the CPU pops bytes via uart_rx_read.
// PARAMETERS
//  PAYLOAD_BITS  8   data bits per frame, LSB first on the line
//  DIV_W         12  width of divider input
//  FIFO_DEPTH    4   receive FIFO entries, power of two, >=2
//  RTS_THRESH    3   FIFO level at or above which RTS is deasserted (uart_rts=1)
// PORTS
//  clk                 in   1                  system clock
//  resetn              in   1                  asynchronous active-low reset
//  uart_rxd            in   1                  serial input, idle high
//  divider             in   DIV_W              clock cycles per bit minus 1; minimum legal value 3
//  cfg_parity_en       in   1                  1: parity bit follows data
//  cfg_parity_odd      in   1                  1: odd parity, 0: even
//  cfg_two_stop        in   1                  1: two stop bits checked
//  uart_rx_read        in   1                  pop head entry (ignored when FIFO empty)
//  err_clear           in   1                  clear sticky overrun/break flags
//  uart_rts            out  1                  active-low request to send
//  uart_rx_valid       out  1                  FIFO not empty
//  uart_rx_data        out  PAYLOAD_BITS       head entry data
//  uart_rx_frame_err   out  1                  head entry had a low stop bit
//  uart_rx_parity_err  out  1                  head entry failed parity
//  uart_rx_level       out  $clog2(DEPTH)+1    FIFO occupancy
//  uart_rx_overrun     out  1                  sticky: frame dropped because FIFO full
//  uart_rx_break       out  1                  sticky: break detected
// BEHAVIOUR
//  Reset (async): FSM IDLE, FIFO empty, flags 0, uart_rts=1, sync flops =1, counter 0; all outputs 0 except uart_rts.
//  uart_rxd passes through a 2-flop synchroniser (reset to 1); all decisions use the synchronised value.
//  divider is latched at start-bit falling edge; changes mid-frame take effect on the next frame.
//  Bit counter counts 0..div_l, wraps to 0; mid-bit sample point at count == div_l>>1.
//  FSM: IDLE -(rx low)-> START -(mid, rx low)-> DATA x PAYLOAD_BITS -> [PARITY if en] -> STOP1 -> [STOP2 if two_stop] -> IDLE.
//   START mid-sample high: glitch, return to IDLE, nothing pushed.
//   Data shifted in LSB first at each mid sample; parity computed over data, compared at PARITY mid.
//   Frame completes at the mid sample of the final stop bit (no wait for bit end); FSM goes IDLE same edge.
//   Any stop bit sampled low sets the entry's frame_err; if additionally data==0 (and parity bit low when enabled)
//   set uart_rx_break and hold FSM in BREAK until rx returns high, then IDLE. Break frame is still pushed.
//  Push: one cycle after the completing sample, {frame_err, parity_err, data} pushed; if FIFO full and no
//   same-cycle pop, entry dropped and uart_rx_overrun set. Push+pop when full: both succeed, no overrun.
//  Pop: uart_rx_read while uart_rx_valid advances head next cycle; read when empty has no effect.
//  Outputs show head entry combinationally from FIFO storage; level updates the cycle after push/pop.
//  uart_rts = (level >= RTS_THRESH), registered, 1-cycle lag. Receiver keeps accepting while RTS high.
//  err_clear clears sticky flags; a same-cycle set wins over clear.
//  Counter width DIV_W; no arithmetic overflow since counter resets at div_l.
//  resetn asserted mid-frame: frame discarded, FIFO emptied, immediately idle.
// STRUCTURE
//  Sub-module uart_rx_fifo: sync FIFO (DEPTH, WIDTH=PAYLOAD_BITS+2), push/pop/full/empty/level, async reset.
//  Shared package uart_pkg: FSM state encoding localparams, FIFO entry field offsets.
//  Top holds synchroniser, bit counter, FSM, shift register, parity, sticky flags, RTS.
// TESTING
//  divider=7, no parity, byte 0xA5 -> after 10 bit times uart_rx_valid=1, data=0xA5, errs=0, level=1.
//  cfg_parity_en=1 odd, send 0x03 with parity bit 0 -> data=0x03, uart_rx_parity_err=1; bit 1 -> err=0.
//  Push 5 bytes into DEPTH=4 without reads -> uart_rts=1 after 3rd, 5th dropped, overrun=1; pops return bytes 1..4.
//  Low pulse of 2 cycles on uart_rxd (divider=7) -> no push, FSM back to IDLE, level stays 0.
//  Hold rxd low 20 bit times -> one entry data=0x00 frame_err=1, uart_rx_break=1; err_clear -> break=0.
//  resetn low mid-data bit 4 -> outputs at reset values; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM states and FIFO entry layout.
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_BREAK  = 3'd6
    } rx_state_t;

    // FIFO entry is {frame_err, parity_err, data}; flag offsets are relative to the top of the data field
    localparam int ENT_PERR_OFS = 0;
    localparam int ENT_FERR_OFS = 1;
    localparam int ENT_FLAG_W   = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with occupancy count; a push into a full FIFO succeeds only with a same-cycle pop.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; everything clears on reset so the head reads as zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: synchroniser, bit timing, frame FSM, parity/framing/break checks,
// receive FIFO with sticky overrun/break flags and registered RTS flow control.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int DIV_W        = 12,
    parameter int FIFO_DEPTH   = 4,
    parameter int RTS_THRESH   = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rxd,
    input  logic [DIV_W-1:0]              divider,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_two_stop,
    input  logic                          uart_rx_read,
    input  logic                          err_clear,
    output logic                          uart_rts,
    output logic                          uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0]       uart_rx_data,
    output logic                          uart_rx_frame_err,
    output logic                          uart_rx_parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   uart_rx_level,
    output logic                          uart_rx_overrun,
    output logic                          uart_rx_break
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = PAYLOAD_BITS + ENT_FLAG_W;
    localparam int BIT_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    logic                    r_sync1, r_sync2;
    rx_state_t               r_state, w_next;
    logic [DIV_W-1:0]        r_cnt, r_div_l;
    logic [BIT_W-1:0]        r_bit;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_pbit, r_perr, r_ferr;
    logic                    r_push;
    logic [ENT_W-1:0]        r_entry;
    logic                    r_overrun, r_break, r_rts;
    logic                    w_rx, w_mid, w_done, w_ferr_final, w_brk_cond;
    logic                    w_full, w_empty;
    logic [ENT_W-1:0]        w_head;
    logic [LVL_W-1:0]        w_level;

    assign w_rx         = r_sync2;
    assign w_mid        = (r_cnt == (r_div_l >> 1));
    assign w_ferr_final = r_ferr | ~w_rx;
    assign w_brk_cond   = w_ferr_final && (r_shift == '0) && (!cfg_parity_en || !r_pbit);

    // Two-flop synchroniser on the serial input, idle high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; w_done marks the mid sample of the final stop bit
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE:   if (!w_rx) w_next = ST_START;
            ST_START:  if (w_mid) w_next = w_rx ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_mid && (r_bit == BIT_W'(PAYLOAD_BITS-1)))
                           w_next = cfg_parity_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (w_mid) w_next = ST_STOP1;
            ST_STOP1:  if (w_mid) begin
                           if (cfg_two_stop) begin
                               w_next = ST_STOP2;
                           end else begin
                               w_done = 1'b1;
                               w_next = w_brk_cond ? ST_BREAK : ST_IDLE;
                           end
                       end
            ST_STOP2:  if (w_mid) begin
                           w_done = 1'b1;
                           w_next = w_brk_cond ? ST_BREAK : ST_IDLE;
                       end
            ST_BREAK:  if (w_rx) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bit timing, shift register, parity/stop capture and the one-cycle-delayed push request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_div_l <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_pbit  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_push  <= 1'b0;
            r_entry <= '0;
        end else begin
            r_push <= w_done;
            if (r_state == ST_IDLE) begin
                r_cnt  <= '0;
                r_bit  <= '0;
                r_pbit <= 1'b0;
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
                if (!w_rx) r_div_l <= divider;
            end else begin
                r_cnt <= (r_cnt == r_div_l) ? '0 : r_cnt + 1'b1;
                if (w_mid) begin
                    case (r_state)
                        ST_DATA: begin
                            r_shift <= {w_rx, r_shift[PAYLOAD_BITS-1:1]};
                            r_bit   <= r_bit + 1'b1;
                        end
                        ST_PARITY: begin
                            r_pbit <= w_rx;
                            r_perr <= (^r_shift) ^ w_rx ^ cfg_parity_odd;
                        end
                        ST_STOP1, ST_STOP2: if (!w_rx) r_ferr <= 1'b1;
                        default: ;
                    endcase
                end
            end
            if (w_done) r_entry <= {w_ferr_final, r_perr, r_shift};
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (r_push),
        .i_pop   (uart_rx_read),
        .i_wdata (r_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Sticky error flags (set beats clear) and RTS registered from FIFO level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
            r_rts     <= 1'b1;
        end else begin
            if (r_push && w_full && !uart_rx_read) r_overrun <= 1'b1;
            else if (err_clear)                    r_overrun <= 1'b0;
            if (w_done && w_brk_cond)              r_break   <= 1'b1;
            else if (err_clear)                    r_break   <= 1'b0;
            r_rts <= (w_level >= LVL_W'(RTS_THRESH));
        end
    end

    assign uart_rts           = r_rts;
    assign uart_rx_valid      = ~w_empty;
    assign uart_rx_data       = w_head[PAYLOAD_BITS-1:0];
    assign uart_rx_parity_err = w_head[PAYLOAD_BITS + ENT_PERR_OFS];
    assign uart_rx_frame_err  = w_head[PAYLOAD_BITS + ENT_FERR_OFS];
    assign uart_rx_level      = w_level;
    assign uart_rx_overrun    = r_overrun;
    assign uart_rx_break      = r_break;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: a frame-level model predicts FIFO entries and flags.
module tb_uart_rx_buffered;
    localparam int PAYLOAD_BITS = 8;
    localparam int DIV_W        = 12;
    localparam int FIFO_DEPTH   = 4;
    localparam int RTS_THRESH   = 3;
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    uart_rxd = 1'b1;
    logic [DIV_W-1:0]        divider = DIV_W'(7);
    logic                    cfg_parity_en = 1'b0;
    logic                    cfg_parity_odd = 1'b0;
    logic                    cfg_two_stop = 1'b0;
    logic                    uart_rx_read = 1'b0;
    logic                    err_clear = 1'b0;
    logic                    uart_rts;
    logic                    uart_rx_valid;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_rx_frame_err;
    logic                    uart_rx_parity_err;
    logic [LVL_W-1:0]        uart_rx_level;
    logic                    uart_rx_overrun;
    logic                    uart_rx_break;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .DIV_W        (DIV_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .RTS_THRESH   (RTS_THRESH)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .uart_rxd           (uart_rxd),
        .divider            (divider),
        .cfg_parity_en      (cfg_parity_en),
        .cfg_parity_odd     (cfg_parity_odd),
        .cfg_two_stop       (cfg_two_stop),
        .uart_rx_read       (uart_rx_read),
        .err_clear          (err_clear),
        .uart_rts           (uart_rts),
        .uart_rx_valid      (uart_rx_valid),
        .uart_rx_data       (uart_rx_data),
        .uart_rx_frame_err  (uart_rx_frame_err),
        .uart_rx_parity_err (uart_rx_parity_err),
        .uart_rx_level      (uart_rx_level),
        .uart_rx_overrun    (uart_rx_overrun),
        .uart_rx_break      (uart_rx_break)
    );

    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         auto_read = 1'b0;
    bit         exp_ovr = 1'b0;
    bit         exp_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model of one frame: what the receiver must store and which flags it must raise
    task automatic model_frame(input logic [7:0] d, input bit par_val, input bit stop_val);
        int  ones;
        bit  perr, ferr;
        ones = $countones({d, par_val});
        perr = cfg_parity_en && (cfg_parity_odd ? (ones % 2 == 0) : (ones % 2 == 1));
        ferr = !stop_val;
        if (ferr && d == 8'h00 && (!cfg_parity_en || !par_val)) exp_brk = 1'b1;
        if (exp_q.size() >= FIFO_DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back({ferr, perr, d});
    endtask

    task automatic send_bit(input logic v, input int cyc);
        uart_rxd = v;
        repeat (cyc) @(negedge clk);
    endtask

    // Drive a complete frame followed by idle_bits of idle line; divider is scrambled mid-frame
    task automatic send_frame(input logic [7:0] d, input int div, input bit par_val,
                              input bit stop_val, input int idle_bits);
        int cyc;
        divider = DIV_W'(div);
        cyc = div + 1;
        model_frame(d, par_val, stop_val);
        send_bit(1'b0, cyc);
        divider = DIV_W'($urandom_range(3, 15));
        for (int i = 0; i < 8; i++) send_bit(d[i], cyc);
        if (cfg_parity_en) send_bit(par_val, cyc);
        send_bit(stop_val, cyc);
        if (cfg_two_stop) send_bit(stop_val, cyc);
        send_bit(1'b1, cyc * idle_bits);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || uart_rx_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_ovr = 1'b0;
        exp_brk = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(uart_rx_valid), 32'd0);
        check({tag, "_level"},   32'(uart_rx_level), 32'd0);
        check({tag, "_data"},    32'({uart_rx_frame_err, uart_rx_parity_err, uart_rx_data}), 32'd0);
        check({tag, "_overrun"}, 32'(uart_rx_overrun), 32'd0);
        check({tag, "_break"},   32'(uart_rx_break), 32'd0);
        check({tag, "_rts"},     32'(uart_rts), 32'd1);
    endtask

    // Monitor: whenever the FIFO presents an entry, compare it with the scoreboard head and pop it
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            uart_rx_read = 1'b0;
            if (auto_read && uart_rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got entry 0x%0h, required none",
                             {uart_rx_frame_err, uart_rx_parity_err, uart_rx_data});
                end else begin
                    e = exp_q.pop_front();
                    check("rx_entry", 32'({uart_rx_frame_err, uart_rx_parity_err, uart_rx_data}), 32'(e));
                end
                uart_rx_read = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         div;
        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_rts", 32'(uart_rts), 32'd0);

        // Short low pulse is rejected as a glitch
        divider = DIV_W'(7);
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_level", 32'(uart_rx_level), 32'd0);
        check("glitch_valid", 32'(uart_rx_valid), 32'd0);

        // Basic frame 0xA5, no parity, held in the FIFO
        send_frame(8'hA5, 7, 1'b0, 1'b1, 2);
        check("a5_valid", 32'(uart_rx_valid), 32'd1);
        check("a5_level", 32'(uart_rx_level), 32'd1);
        check("a5_head",  32'({uart_rx_frame_err, uart_rx_parity_err, uart_rx_data}), 32'h0A5);
        auto_read = 1'b1;
        wait_drain();

        // Odd parity on 0x03
        cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b1;
        send_frame(8'h03, 7, 1'b0, 1'b1, 2);
        send_frame(8'h03, 7, 1'b1, 1'b1, 2);
        wait_drain();
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;

        // Fill past depth without reading: RTS at threshold, fifth frame dropped
        auto_read = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(8'h30 + i), 7, 1'b0, 1'b1, 2);
            check("fill_level", 32'(uart_rx_level), 32'((i < FIFO_DEPTH) ? i : FIFO_DEPTH));
            check("fill_rts", 32'(uart_rts), 32'((i >= RTS_THRESH) ? 1 : 0));
        end
        check("overrun_set", 32'(uart_rx_overrun), 32'(exp_ovr));
        auto_read = 1'b1;
        wait_drain();
        check("drained_rts", 32'(uart_rts), 32'd0);
        pulse_clear();
        check("overrun_clr", 32'(uart_rx_overrun), 32'd0);

        // Line held low for 20 bit times: one break entry
        auto_read = 1'b0;
        model_frame(8'h00, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        repeat (20 * 8) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (16) @(negedge clk);
        check("break_level", 32'(uart_rx_level), 32'd1);
        check("break_flag",  32'(uart_rx_break), 32'(exp_brk));
        auto_read = 1'b1;
        wait_drain();
        pulse_clear();
        check("break_clr", 32'(uart_rx_break), 32'd0);

        // Reset during data bit 4 with an entry already queued
        auto_read = 1'b0;
        send_frame(8'h11, 7, 1'b0, 1'b1, 2);
        d = 8'h5A;
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(d[i], 8);
        uart_rxd = d[4];
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_brk = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        auto_read = 1'b1;
        send_frame(8'h5A, 7, 1'b0, 1'b1, 2);
        wait_drain();

        // Randomised frames across divider, parity and stop configurations
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            div = $urandom_range(3, 15);
            cfg_parity_en  = 1'($urandom_range(0, 1));
            cfg_parity_odd = 1'($urandom_range(0, 1));
            cfg_two_stop   = 1'($urandom_range(0, 1));
            send_frame(d, div, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 3);
            wait_drain();
            check("rand_break",   32'(uart_rx_break), 32'(exp_brk));
            check("rand_overrun", 32'(uart_rx_overrun), 32'(exp_ovr));
            if (exp_brk) pulse_clear();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
